// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp codes, R-type Funct values, slice select
// encodings and the decoded control bundle. Used by the ID/EX stage and
// by anything that drives the 1-bit-slice ALU directly.
package alu_pkg;

    localparam int ALUOP_W = 2;
    localparam int FUNCT_W = 6;

    // Main-control ALUOp field
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;  // lw/sw address
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;  // beq compare
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

    // R-type function field
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // Per-slice result select
    typedef enum logic [1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_ADD = 2'b10,
        SEL_SLT = 2'b11
    } sel_e;

    // Everything the ALU slices need from decode, plus the decode-error flag
    typedef struct packed {
        sel_e sel;
        logic invertB;
        logic cin;
        logic illegal;
    } aluCtrl_t;

    // Safe default: plain add, no inversion; also what undecodable ops map to
    localparam aluCtrl_t ALU_CTRL_ADD = '{sel: SEL_ADD, invertB: 1'b0, cin: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_control.sv
// ALUOp/Funct -> slice controls (Sel, InvertB, Cin) plus an Illegal flag.
// Purely combinational so the ALU bench can drive it stand-alone.
module alu_control
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic [FUNCT_W-1:0] funct,
    output aluCtrl_t           ctrl
);

    // Subtraction is A + ~B + 1, so sub/beq/slt all set InvertB and Cin together.
    always_comb begin
        ctrl = ALU_CTRL_ADD;
        case (aluOp)
            ALUOP_ADD: begin
                ctrl = ALU_CTRL_ADD;
            end
            ALUOP_SUB: begin
                ctrl.sel     = SEL_ADD;
                ctrl.invertB = 1'b1;
                ctrl.cin     = 1'b1;
            end
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: begin
                        ctrl.sel = SEL_ADD;
                    end
                    FUNCT_SUB: begin
                        ctrl.sel     = SEL_ADD;
                        ctrl.invertB = 1'b1;
                        ctrl.cin     = 1'b1;
                    end
                    FUNCT_AND: begin
                        ctrl.sel = SEL_AND;
                    end
                    FUNCT_OR: begin
                        ctrl.sel = SEL_OR;
                    end
                    FUNCT_SLT: begin
                        ctrl.sel     = SEL_SLT;
                        ctrl.invertB = 1'b1;
                        ctrl.cin     = 1'b1;
                    end
                    default: begin
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                // ALUOP_RSVD
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 1-bit-slice ALU. Captures decoded
// operands/control from ID with a valid/ready handshake, supports flush
// (bubble insertion) and registers the ALU slice controls.
// Optional build macro ID_EX_FORWARD_EN adds the EX/MEM and MEM/WB
// forwarding network on the operand outputs; without it operands come
// straight from the registered register-file reads.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic                 Flush,
    input  logic [ALUOP_W-1:0]   ALUOp,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic [WIDTH-1:0]     ReadData1,
    input  logic [WIDTH-1:0]     ReadData2,
    input  logic [WIDTH-1:0]     SignExtImm,
    input  logic                 ALUSrc,
    input  logic                 RegDst,
    input  logic                 RegWrite,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 MemtoReg,
    input  logic [REGW-1:0]      Rs,
    input  logic [REGW-1:0]      Rt,
    input  logic [REGW-1:0]      Rd,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [1:0]           Sel,
    output logic                 InvertB,
    output logic                 Cin,
    output logic [WIDTH-1:0]     OpA,
    output logic [WIDTH-1:0]     OpB,
    output logic [WIDTH-1:0]     StoreData,
    output logic [REGW-1:0]      WriteReg,
    output logic                 ExRegWrite,
    output logic                 ExMemRead,
    output logic                 ExMemWrite,
    output logic                 ExMemtoReg,
    output logic                 Illegal
`ifdef ID_EX_FORWARD_EN
    ,
    input  logic                 ExMemRegWrite,
    input  logic [REGW-1:0]      ExMemRd,
    input  logic [WIDTH-1:0]     ExMemResult,
    input  logic                 MemWbRegWrite,
    input  logic [REGW-1:0]      MemWbRd,
    input  logic [WIDTH-1:0]     MemWbResult
`endif
);

    aluCtrl_t           idCtrl;
    logic               capture;

    logic               validQ;
    aluCtrl_t           ctrlQ;
    logic [WIDTH-1:0]   rd1Q;
    logic [WIDTH-1:0]   rd2Q;
    logic [WIDTH-1:0]   immQ;
    logic               aluSrcQ;
    logic               regWriteQ;
    logic               memReadQ;
    logic               memWriteQ;
    logic               memtoRegQ;
    logic [REGW-1:0]    writeRegQ;

    logic [WIDTH-1:0]   rsValue;
    logic [WIDTH-1:0]   rtValue;

    alu_control uAluControl (
        .aluOp (ALUOp),
        .funct (Funct),
        .ctrl  (idCtrl)
    );

    // Reset forces ready so ID never sees a stale stall while the pipe is being cleared.
    assign InReady = rst | ~validQ | OutReady;
    assign capture = InValid & InReady & ~Flush;

    // Valid bit: flush beats capture beats drain; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= 1'b0;
        end else if (Flush) begin
            validQ <= 1'b0;
        end else if (capture) begin
            validQ <= 1'b1;
        end else if (OutReady) begin
            validQ <= 1'b0;
        end
    end

    // Payload registers load only on capture; drained slots keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlQ     <= '{sel: SEL_AND, invertB: 1'b0, cin: 1'b0, illegal: 1'b0};
            rd1Q      <= '0;
            rd2Q      <= '0;
            immQ      <= '0;
            aluSrcQ   <= 1'b0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memtoRegQ <= 1'b0;
            writeRegQ <= '0;
        end else if (capture) begin
            ctrlQ     <= idCtrl;
            rd1Q      <= ReadData1;
            rd2Q      <= ReadData2;
            immQ      <= SignExtImm;
            aluSrcQ   <= ALUSrc;
            regWriteQ <= RegWrite;
            memReadQ  <= MemRead;
            memWriteQ <= MemWrite;
            memtoRegQ <= MemtoReg;
            writeRegQ <= RegDst ? Rd : Rt;
        end
    end

`ifdef ID_EX_FORWARD_EN
    logic [REGW-1:0]    rsQ;
    logic [REGW-1:0]    rtQ;

    // Source indices are only needed to match against later-stage destinations.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsQ <= '0;
            rtQ <= '0;
        end else if (capture) begin
            rsQ <= Rs;
            rtQ <= Rt;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; $zero never forwards.
    always_comb begin
        rsValue = rd1Q;
        rtValue = rd2Q;
        if (ExMemRegWrite && (ExMemRd == rsQ) && (rsQ != '0)) begin
            rsValue = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd == rsQ) && (rsQ != '0)) begin
            rsValue = MemWbResult;
        end
        if (ExMemRegWrite && (ExMemRd == rtQ) && (rtQ != '0)) begin
            rtValue = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd == rtQ) && (rtQ != '0)) begin
            rtValue = MemWbResult;
        end
    end
`else
    // Rs is only consumed by the forwarding network.
    logic unusedRs;
    assign unusedRs = ^Rs;

    // Without forwarding, hazards are resolved upstream by stalling.
    always_comb begin
        rsValue = rd1Q;
        rtValue = rd2Q;
    end
`endif

    assign OutValid   = validQ;
    assign Sel        = ctrlQ.sel;
    assign InvertB    = ctrlQ.invertB;
    assign Cin        = ctrlQ.cin;
    assign OpA        = rsValue;
    assign OpB        = aluSrcQ ? immQ : rtValue;
    assign StoreData  = rtValue;
    assign WriteReg   = writeRegQ;

    // Side-effecting controls are qualified so a bubble can never write state.
    assign ExRegWrite = validQ & regWriteQ;
    assign ExMemRead  = validQ & memReadQ;
    assign ExMemWrite = validQ & memWriteQ;
    assign ExMemtoReg = memtoRegQ;
    assign Illegal    = validQ & ctrlQ.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX-side outputs,
// pushed when an instruction is captured and compared while it is held.
// Forwarding checks are compiled in only with ID_EX_FORWARD_EN.
module tb_id_ex_stage;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int REGW  = 5;

    logic clk = 1'b0;
    logic rst;
    logic InValid, InReady, Flush;
    logic [1:0] ALUOp;
    logic [5:0] Funct;
    logic [WIDTH-1:0] ReadData1, ReadData2, SignExtImm;
    logic ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
    logic [REGW-1:0] Rs, Rt, Rd;
    logic OutValid, OutReady;
    logic [1:0] Sel;
    logic InvertB, Cin;
    logic [WIDTH-1:0] OpA, OpB, StoreData;
    logic [REGW-1:0] WriteReg;
    logic ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, Illegal;
`ifdef ID_EX_FORWARD_EN
    logic ExMemRegWrite, MemWbRegWrite;
    logic [REGW-1:0] ExMemRd, MemWbRd;
    logic [WIDTH-1:0] ExMemResult, MemWbResult;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .Flush(Flush),
        .ALUOp(ALUOp), .Funct(Funct), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .SignExtImm(SignExtImm), .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .OutValid(OutValid), .OutReady(OutReady),
        .Sel(Sel), .InvertB(InvertB), .Cin(Cin), .OpA(OpA), .OpB(OpB),
        .StoreData(StoreData), .WriteReg(WriteReg), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemtoReg(ExMemtoReg),
        .Illegal(Illegal)
`ifdef ID_EX_FORWARD_EN
        , .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult)
`endif
    );

    typedef struct packed {
        logic [1:0] aluOp;
        logic [5:0] funct;
        logic [31:0] a, b, imm;
        logic aluSrc, regDst, regWrite, memRead, memWrite, memtoReg;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct packed {
        logic [1:0] sel;
        logic invB, cin, illegal;
        logic [31:0] opA, opB, storeData;
        logic [4:0] writeReg;
        logic regWrite, memRead, memWrite, memtoReg;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    function automatic instr_t mk(logic [1:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b);
        instr_t i;
        i = '0;
        i.aluOp = op; i.funct = fn; i.a = a; i.b = b;
        return i;
    endfunction

    // Reference model written from the decode table
    function automatic exp_t model(instr_t i);
        exp_t e;
        e = '0;
        e.sel = 2'b10;
        case (i.aluOp)
            2'b00: ;
            2'b01: begin e.invB = 1'b1; e.cin = 1'b1; end
            2'b10: begin
                case (i.funct)
                    6'b100000: ;
                    6'b100010: begin e.invB = 1'b1; e.cin = 1'b1; end
                    6'b100100: e.sel = 2'b00;
                    6'b100101: e.sel = 2'b01;
                    6'b101010: begin e.sel = 2'b11; e.invB = 1'b1; e.cin = 1'b1; end
                    default:   e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        e.opA = i.a;
        e.opB = i.aluSrc ? i.imm : i.b;
        e.storeData = i.b;
        e.writeReg = i.regDst ? i.rd : i.rt;
        e.regWrite = i.regWrite; e.memRead = i.memRead;
        e.memWrite = i.memWrite; e.memtoReg = i.memtoReg;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        ALUOp = i.aluOp; Funct = i.funct; ReadData1 = i.a; ReadData2 = i.b;
        SignExtImm = i.imm; ALUSrc = i.aluSrc; RegDst = i.regDst; RegWrite = i.regWrite;
        MemRead = i.memRead; MemWrite = i.memWrite; MemtoReg = i.memtoReg;
        Rs = i.rs; Rt = i.rt; Rd = i.rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag);
        exp_t e;
        chk({tag, ".sbNonEmpty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb[0];
            chk({tag, ".OutValid"}, 32'(OutValid), 32'd1);
            chk({tag, ".Sel"}, 32'(Sel), 32'(e.sel));
            chk({tag, ".InvertB"}, 32'(InvertB), 32'(e.invB));
            chk({tag, ".Cin"}, 32'(Cin), 32'(e.cin));
            chk({tag, ".Illegal"}, 32'(Illegal), 32'(e.illegal));
            chk({tag, ".OpA"}, OpA, e.opA);
            chk({tag, ".OpB"}, OpB, e.opB);
            chk({tag, ".StoreData"}, StoreData, e.storeData);
            chk({tag, ".WriteReg"}, 32'(WriteReg), 32'(e.writeReg));
            chk({tag, ".ExRegWrite"}, 32'(ExRegWrite), 32'(e.regWrite));
            chk({tag, ".ExMemRead"}, 32'(ExMemRead), 32'(e.memRead));
            chk({tag, ".ExMemWrite"}, 32'(ExMemWrite), 32'(e.memWrite));
            chk({tag, ".ExMemtoReg"}, 32'(ExMemtoReg), 32'(e.memtoReg));
        end
    endtask

    task automatic retire();
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    instr_t i;
    instr_t lst[5];

    initial begin
        rst = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        drive('0);
`ifdef ID_EX_FORWARD_EN
        ExMemRegWrite = 1'b0; ExMemRd = '0; ExMemResult = '0;
        MemWbRegWrite = 1'b0; MemWbRd = '0; MemWbResult = '0;
`endif
        // Reset for two cycles
        step();
        chk("rst.InReady", 32'(InReady), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rst.OutValid", 32'(OutValid), 32'd0);
        chk("rst.InReady2", 32'(InReady), 32'd1);
        chk("rst.Sel", 32'(Sel), 32'd0);
        chk("rst.InvertB", 32'(InvertB), 32'd0);
        chk("rst.Cin", 32'(Cin), 32'd0);
        chk("rst.OpA", OpA, 32'd0);
        chk("rst.OpB", OpB, 32'd0);
        chk("rst.StoreData", StoreData, 32'd0);
        chk("rst.WriteReg", 32'(WriteReg), 32'd0);
        chk("rst.ctl", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg, Illegal}), 32'd0);

        // R-type sub
        i = mk(2'b10, 6'b100010, 32'd10, 32'd3);
        i.regDst = 1'b1; i.rd = 5'd7; i.rt = 5'd3; i.rs = 5'd2; i.regWrite = 1'b1;
        drive(i); InValid = 1'b1;
        sb.push_back(model(i));
        step();
        checkHead("sub");

        // Stall three cycles with a new instruction waiting
        i = mk(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0);
        i.regDst = 1'b1; i.rd = 5'd8; i.regWrite = 1'b1;
        drive(i); OutReady = 1'b0;
        #1;
        chk("stall.InReady", 32'(InReady), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkHead("hold");
            chk("hold.InReady", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        #1;
        chk("release.InReady", 32'(InReady), 32'd1);
        retire();
        sb.push_back(model(i));
        step();
        checkHead("and");

        // OR with immediate operand, store-type controls
        i = mk(2'b10, 6'b100101, 32'h1000_0001, 32'hDEAD_BEEF);
        i.aluSrc = 1'b1; i.imm = 32'h0000_1234; i.rt = 5'd9; i.memWrite = 1'b1;
        retire();
        sb.push_back(model(i));
        drive(i);
        step();
        checkHead("orImm");

        // Flush while holding, with InValid high
        OutReady = 1'b0;
        i = mk(2'b10, 6'b101010, 32'd5, 32'd6);
        i.regWrite = 1'b1;
        drive(i); Flush = 1'b1;
        step();
        retire();
        chk("flush.OutValid", 32'(OutValid), 32'd0);
        chk("flush.ExRegWrite", 32'(ExRegWrite), 32'd0);
        chk("flush.ExMemWrite", 32'(ExMemWrite), 32'd0);
        chk("flush.Illegal", 32'(Illegal), 32'd0);
        // Flush on an empty stage with ready high must still block capture
        OutReady = 1'b1;
        step();
        chk("flushEmpty.OutValid", 32'(OutValid), 32'd0);
        Flush = 1'b0; InValid = 1'b0;
        step();
        chk("postFlush.OutValid", 32'(OutValid), 32'd0);

        // Back-to-back decode sweep at full throughput
        lst[0] = mk(2'b10, 6'b000111, 32'd1, 32'd2);
        lst[0].regWrite = 1'b1;
        lst[1] = mk(2'b11, 6'b100000, 32'd3, 32'd4);
        lst[2] = mk(2'b10, 6'b101010, 32'd5, 32'd6);
        lst[2].regDst = 1'b1; lst[2].rd = 5'd31; lst[2].regWrite = 1'b1;
        lst[3] = mk(2'b00, 6'b000000, 32'h0000_0100, 32'd9);
        lst[3].aluSrc = 1'b1; lst[3].imm = 32'hFFFF_FFFC; lst[3].memRead = 1'b1;
        lst[3].memtoReg = 1'b1; lst[3].regWrite = 1'b1; lst[3].rt = 5'd12;
        lst[4] = mk(2'b01, 6'b111111, 32'd7, 32'd7);
        InValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(lst[k]);
            sb.push_back(model(lst[k]));
            step();
            checkHead($sformatf("sweep%0d", k));
            retire();
        end
        InValid = 1'b0;
        step();
        chk("drain.OutValid", 32'(OutValid), 32'd0);
        chk("drain.ctl", 32'({ExRegWrite, ExMemRead, ExMemWrite, Illegal}), 32'd0);

        // Reset asserted while an instruction is held
        i = mk(2'b10, 6'b100000, 32'd1, 32'd2);
        i.regWrite = 1'b1;
        drive(i); InValid = 1'b1;
        sb.push_back(model(i));
        step();
        checkHead("preRst");
        retire();
        InValid = 1'b0; OutReady = 1'b0;
        step();
        chk("preRst.held", 32'(OutValid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstHold.InReady", 32'(InReady), 32'd1);
        step();
        chk("rstHold.OutValid", 32'(OutValid), 32'd0);
        chk("rstHold.OpA", OpA, 32'd0);
        chk("rstHold.ExRegWrite", 32'(ExRegWrite), 32'd0);
        rst = 1'b0; OutReady = 1'b1;

`ifdef ID_EX_FORWARD_EN
        // EX/MEM beats MEM/WB, then fall back through the chain
        i = mk(2'b10, 6'b100000, 32'h11, 32'h22);
        i.rs = 5'd5; i.rt = 5'd6;
        drive(i); InValid = 1'b1;
        step();
        InValid = 1'b0;
        ExMemRegWrite = 1'b1; ExMemRd = 5'd5; ExMemResult = 32'h55;
        MemWbRegWrite = 1'b1; MemWbRd = 5'd5; MemWbResult = 32'h66;
        #1;
        chk("fwd.exMem", OpA, 32'h55);
        chk("fwd.rtNoMatch", OpB, 32'h22);
        ExMemRegWrite = 1'b0;
        #1;
        chk("fwd.memWb", OpA, 32'h66);
        MemWbRegWrite = 1'b0;
        #1;
        chk("fwd.none", OpA, 32'h11);

        // $zero never forwards; Rt forwarding reaches both OpB and StoreData
        i = mk(2'b10, 6'b100000, 32'h77, 32'h88);
        i.rs = 5'd0; i.rt = 5'd6;
        drive(i); InValid = 1'b1;
        ExMemRegWrite = 1'b1; ExMemRd = 5'd0; ExMemResult = 32'h55;
        MemWbRegWrite = 1'b1; MemWbRd = 5'd6; MemWbResult = 32'h66;
        step();
        InValid = 1'b0;
        chk("fwd.zeroRs", OpA, 32'h77);
        chk("fwd.rtOpB", OpB, 32'h66);
        chk("fwd.rtStore", StoreData, 32'h66);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register that sits directly upstream of the 32-bit ALU built from 1-bit slices. Each cycle it captures decoded operands and control from ID, translates ALUOp/Funct into the ALU slice controls (Sel, InvertB, Cin), and presents operands to EX. A valid/ready handshake provides stall, and a flush input provides bubble insertion. An optional forwarding network selects operands from later stages.

## Interface
Parameters:
- WIDTH, 32, datapath width (operands, immediate, results)
- REGW, 5, register-index width

Ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- InValid  in  1  ID presents a valid instruction
- InReady  out  1  stage can accept this cycle
- Flush  in  1  discard the held instruction and block capture
- ALUOp  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 reserved
- Funct  in  6  R-type function field
- ReadData1, ReadData2  in  WIDTH  register-file reads for Rs, Rt
- SignExtImm  in  WIDTH  sign-extended immediate
- ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg  in  1 each  main-control bits
- Rs, Rt, Rd  in  REGW  register indices
- OutValid  out  1  EX holds a valid instruction
- OutReady  in  1  EX/MEM accepts this cycle
- Sel  out  2  ALU select: 00 AND, 01 OR, 10 add/sub, 11 slt
- InvertB, Cin  out  1 each  ALU B-invert and carry-in
- OpA, OpB  out  WIDTH  ALU operands
- StoreData  out  WIDTH  forwarded Rt value for sw
- WriteReg  out  REGW  Rd if RegDst else Rt
- ExRegWrite, ExMemRead, ExMemWrite, ExMemtoReg  out  1 each  registered control
- Illegal  out  1  held instruction has an undecodable ALUOp/Funct
- Forwarding inputs (only with ID_EX_FORWARD_EN): ExMemRegWrite in 1, ExMemRd in REGW, ExMemResult in WIDTH, MemWbRegWrite in 1, MemWbRd in REGW, MemWbResult in WIDTH

## Operation
- Decode: ALUOp 00 -> Sel 10, InvertB 0, Cin 0. ALUOp 01 -> Sel 10, InvertB 1, Cin 1.
- Decode, ALUOp 10, by Funct:
  - 100000 add -> 10/0/0
  - 100010 sub -> 10/1/1
  - 100100 and -> 00/0/0
  - 100101 or -> 01/0/0
  - 101010 slt -> 11/1/1
  - any other Funct, or ALUOp 11 -> Sel 10/0/0 with Illegal=1
- Decode runs on ID inputs. Sel/InvertB/Cin/Illegal are registered.
- InReady = !OutValid | OutReady. Capture occurs when InValid & InReady & !Flush.
- Flush sets OutValid=0 next cycle. It overrides capture and OutReady.
- Hold (OutValid & !OutReady & !Flush): every register keeps its value.
- If no capture and no flush with OutReady=1, OutValid drops to 0 and data registers may keep stale values.
- OpA = forwarded Rs value. OpB = SignExtImm if ALUSrc, else forwarded Rt value. StoreData = forwarded Rt value regardless of ALUSrc.
- Bubbles (OutValid=0) force ExRegWrite, ExMemRead, ExMemWrite and Illegal to 0.

## Timing
- Latency: 1 cycle from capture to OutValid.
- Throughput: 1 per cycle when OutReady=1.
- Reset values: OutValid 0, all control outputs 0, Sel 00, InvertB 0, Cin 0, OpA/OpB/StoreData/WriteReg 0, Illegal 0.
- InReady is 1 during reset.
- Reset asserted mid-hold drops the instruction.
- Forwarding muxes are combinational on the registered Rs/Rt, so forwarded operands follow ExMem*/MemWb* inputs within the cycle.

## Configuration
- Macro: ID_EX_FORWARD_EN.
- Defined: forward a register (Rs or Rt) from EX/MEM when ExMemRegWrite, ExMemRd == reg, and reg != 0. Otherwise forward from MEM/WB under the same conditions. Otherwise use the registered read data. EX/MEM has priority.
- Undefined: forwarding ports are absent and operands come only from registered read data; hazards are handled by stalling.

## Structure
- Shared package alu_pkg holds:
  - ALUOp codes
  - Funct constants
  - Sel encodings (SEL_AND, SEL_OR, SEL_ADD, SEL_SLT)
  - control bundle typedef
- Sub-module alu_control: combinational ALUOp/Funct -> Sel/InvertB/Cin/Illegal decode, reusable by the ALU test bench.

## Test plan
- Reset held for 2 cycles -> OutValid 0, InReady 1, all outputs 0.
- Capture ALUOp 10, Funct 100010, A=10, B=3 -> next cycle OutValid 1, Sel 10, InvertB 1, Cin 1, OpA 10, OpB 3.
- OutReady low for 3 cycles with a new InValid -> InReady 0 and outputs unchanged. OutReady high -> the new instruction appears the following cycle.
- Flush together with InValid and held data -> next cycle OutValid 0 and ExRegWrite 0, with no capture.
- Funct 000111 -> Illegal 1 and Sel 10. ALUOp 11 -> Illegal 1.
- With ID_EX_FORWARD_EN:
  - Rs=5, ExMemRd=5 (result 0x55), MemWbRd=5 (0x66) -> OpA 0x55.
  - Rs=0 with ExMemRd=0 -> OpA is the register-file value.
